// File: rtl/reset_pkg.sv
// Shared types and helpers for the reset sequencer.
package reset_pkg;

    // Sequencer states: wait for synchronised release, hold all resets,
    // release domains one by one, then run.
    typedef enum logic [1:0] {
        ST_SYNC    = 2'd0,
        ST_HOLD    = 2'd1,
        ST_RELEASE = 2'd2,
        ST_RUN     = 2'd3
    } rst_state_e;

    // Width of a counter that must reach the larger of a and b.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/reset_sync_chain.sv
// Reset synchroniser: asserts immediately with async_rst, deasserts only
// after STAGES clock edges with async_rst low.
module reset_sync_chain #(
    parameter int STAGES = 3
) (
    input  logic clk,
    input  logic async_rst,
    output logic sync_ok,
    output logic sync_arm
);

    (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] chain;

    // Shift ones in from the LSB; any async_rst pulse, however short, clears the chain.
    // NOTE: sequential state uses <= so every flop samples the pre-edge value of its neighbour.
    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], 1'b1};
        end
    end

    // sync_ok is the filtered release; sync_arm says it rises on the coming edge.
    assign sync_ok  = chain[STAGES-1];
    assign sync_arm = chain[STAGES-2];

endmodule

// File: rtl/reset_sequencer.sv
// Reset controller: synchronises async_rst release, holds all domain resets
// for a minimum time, then releases them LSB first, STAGGER_CYCLES apart.
// A software request re-runs the hold and release sequence.
module reset_sequencer
    import reset_pkg::*;
#(
    parameter int SYNC_STAGES       = 3,
    parameter int NUM_DOMAINS       = 4,
    parameter int MIN_ASSERT_CYCLES = 8,
    parameter int STAGGER_CYCLES    = 16
) (
    input  logic                   clk,
    input  logic                   async_rst,
    input  logic                   sw_rst_req,
    output logic [NUM_DOMAINS-1:0] dom_rst,
    output logic                   rst_done,
    output logic                   seq_busy
);

    localparam int CNT_W = cnt_width(MIN_ASSERT_CYCLES, STAGGER_CYCLES);
    localparam int IDX_W = $clog2(NUM_DOMAINS + 1);

    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(MIN_ASSERT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(NUM_DOMAINS - 1);

    // Reject parameter sets the sequencer cannot implement.
    if (SYNC_STAGES < 2) begin : g_bad_sync_stages
        $error("reset_sequencer: SYNC_STAGES must be >= 2");
    end
    if (NUM_DOMAINS < 1) begin : g_bad_num_domains
        $error("reset_sequencer: NUM_DOMAINS must be >= 1");
    end
    if (MIN_ASSERT_CYCLES < 1) begin : g_bad_min_assert
        $error("reset_sequencer: MIN_ASSERT_CYCLES must be >= 1");
    end
    if (STAGGER_CYCLES < 1) begin : g_bad_stagger
        $error("reset_sequencer: STAGGER_CYCLES must be >= 1");
    end

    logic sync_ok;
    logic sync_arm;

    rst_state_e             state,       state_nxt;
    logic [CNT_W-1:0]       cnt,         cnt_nxt;
    logic [IDX_W-1:0]       idx,         idx_nxt;
    logic [NUM_DOMAINS-1:0] dom_rst_nxt;
    logic                   rst_done_nxt;
    logic                   seq_busy_nxt;

    reset_sync_chain #(
        .STAGES    (SYNC_STAGES)
    ) u_sync (
        .clk       (clk),
        .async_rst (async_rst),
        .sync_ok   (sync_ok),
        .sync_arm  (sync_arm)
    );

    // Next-state and next-output logic; outputs are registered below so
    // sw_rst_req never reaches dom_rst combinationally.
    // NOTE: every signal gets its hold-value default first, so no path can infer a latch.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        idx_nxt      = idx;
        dom_rst_nxt  = dom_rst;
        rst_done_nxt = rst_done;
        seq_busy_nxt = seq_busy;

        unique case (state)
            ST_SYNC: begin
                // Leave on the edge where the synchroniser output rises.
                if (sync_arm || sync_ok) begin
                    state_nxt    = ST_HOLD;
                    cnt_nxt      = '0;
                    idx_nxt      = '0;
                    dom_rst_nxt  = '1;
                    rst_done_nxt = 1'b0;
                    seq_busy_nxt = 1'b1;
                end
            end

            ST_HOLD: begin
                if (cnt == HOLD_LAST) begin
                    cnt_nxt        = '0;
                    dom_rst_nxt[0] = 1'b0;
                    if (NUM_DOMAINS == 1) begin
                        state_nxt    = ST_RUN;
                        idx_nxt      = '0;
                        rst_done_nxt = 1'b1;
                        seq_busy_nxt = 1'b0;
                    end else begin
                        state_nxt = ST_RELEASE;
                        idx_nxt   = IDX_W'(1);
                    end
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end

            ST_RELEASE: begin
                if (cnt == STAGGER_LAST) begin
                    cnt_nxt = '0;
                    for (int k = 0; k < NUM_DOMAINS; k++) begin
                        if (k == int'(idx)) begin
                            dom_rst_nxt[k] = 1'b0;
                        end
                    end
                    if (idx == IDX_LAST) begin
                        state_nxt    = ST_RUN;
                        idx_nxt      = '0;
                        rst_done_nxt = 1'b1;
                        seq_busy_nxt = 1'b0;
                    end else begin
                        idx_nxt = idx + IDX_W'(1);
                    end
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end

            ST_RUN: begin
                // All domains released; only a request or async_rst leaves here.
            end

            default: begin
                state_nxt = ST_SYNC;
            end
        endcase

        // Software request restarts the hold from any post-sync state.
        if (sw_rst_req && (state != ST_SYNC)) begin
            state_nxt    = ST_HOLD;
            cnt_nxt      = '0;
            idx_nxt      = '0;
            dom_rst_nxt  = '1;
            rst_done_nxt = 1'b0;
            seq_busy_nxt = 1'b1;
        end
    end

    // State, counters and all outputs, forced to the full-reset state by async_rst.
    // NOTE: every flop here sits on the async reset; there is no storage array that could be left unreset.
    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            state    <= ST_SYNC;
            cnt      <= '0;
            idx      <= '0;
            dom_rst  <= '1;
            rst_done <= 1'b0;
            seq_busy <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            idx      <= idx_nxt;
            dom_rst  <= dom_rst_nxt;
            rst_done <= rst_done_nxt;
            seq_busy <= seq_busy_nxt;
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: three parameter sets share clk,
// async_rst and sw_rst_req; expected outputs come from release-edge arithmetic.
module tb_reset_sequencer;

    logic clk = 1'b0;
    logic async_rst;
    logic sw_rst_req;

    logic [3:0] dom_a;
    logic       done_a, busy_a;
    logic [0:0] dom_b;
    logic       done_b, busy_b;
    logic [7:0] dom_c;
    logic       done_c, busy_c;

    int n_compared   = 0;
    int n_mismatched = 0;

    always #5 clk = ~clk;

    // Defaults: SYNC 3, 4 domains, hold 8, stagger 16.
    reset_sequencer u_dut_a (
        .clk        (clk),
        .async_rst  (async_rst),
        .sw_rst_req (sw_rst_req),
        .dom_rst    (dom_a),
        .rst_done   (done_a),
        .seq_busy   (busy_a)
    );

    // Minimal: SYNC 2, 1 domain, hold 1, stagger 1.
    reset_sequencer #(
        .SYNC_STAGES       (2),
        .NUM_DOMAINS       (1),
        .MIN_ASSERT_CYCLES (1),
        .STAGGER_CYCLES    (1)
    ) u_dut_b (
        .clk        (clk),
        .async_rst  (async_rst),
        .sw_rst_req (sw_rst_req),
        .dom_rst    (dom_b),
        .rst_done   (done_b),
        .seq_busy   (busy_b)
    );

    // Wide: SYNC 3, 8 domains, hold 8, stagger 3.
    reset_sequencer #(
        .SYNC_STAGES       (3),
        .NUM_DOMAINS       (8),
        .MIN_ASSERT_CYCLES (8),
        .STAGGER_CYCLES    (3)
    ) u_dut_c (
        .clk        (clk),
        .async_rst  (async_rst),
        .sw_rst_req (sw_rst_req),
        .dom_rst    (dom_c),
        .rst_done   (done_c),
        .seq_busy   (busy_c)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Number of domains released at edge e, given T0, hold, stagger and domain count.
    function automatic int released(input int e, input int t0, input int mn, input int st, input int n);
        int r;
        if (e < t0 + mn) return 0;
        r = (e - t0 - mn) / st + 1;
        return (r > n) ? n : r;
    endfunction

    function automatic logic [31:0] exp_dom(input int n, input int rel);
        logic [31:0] all_mask;
        logic [31:0] rel_mask;
        all_mask = (32'd1 << n) - 32'd1;
        rel_mask = (32'd1 << rel) - 32'd1;
        return all_mask & ~rel_mask;
    endfunction

    // Compare all three instances at edge e against their own T0.
    task automatic check_all(input string tag, input int e, input int ta, input int tb, input int tc);
        int          ra, rb, rc;
        logic [7:0]  inv_c;
        ra = released(e, ta, 8, 16, 4);
        rb = released(e, tb, 1, 1, 1);
        rc = released(e, tc, 8, 3, 8);
        check($sformatf("%s e%0d a.dom", tag, e),  32'(dom_a),  exp_dom(4, ra));
        check($sformatf("%s e%0d a.done", tag, e), 32'(done_a), 32'(ra == 4));
        check($sformatf("%s e%0d a.busy", tag, e), 32'(busy_a), 32'((e >= ta) && (ra < 4)));
        check($sformatf("%s e%0d b.dom", tag, e),  32'(dom_b),  exp_dom(1, rb));
        check($sformatf("%s e%0d b.done", tag, e), 32'(done_b), 32'(rb == 1));
        check($sformatf("%s e%0d b.busy", tag, e), 32'(busy_b), 32'((e >= tb) && (rb < 1)));
        check($sformatf("%s e%0d c.dom", tag, e),  32'(dom_c),  exp_dom(8, rc));
        check($sformatf("%s e%0d c.done", tag, e), 32'(done_c), 32'(rc == 8));
        check($sformatf("%s e%0d c.busy", tag, e), 32'(busy_c), 32'((e >= tc) && (rc < 8)));
        // Shape invariants: released bits are a contiguous run from bit 0.
        inv_c = ~dom_c;
        check($sformatf("%s e%0d c.thermo", tag, e), 32'(inv_c & (inv_c + 8'd1)), 32'd0);
        check($sformatf("%s e%0d a.done_eq", tag, e), 32'(done_a), 32'(dom_a == 4'h0));
    endtask

    task automatic run_edges(input string tag, input int first, input int last,
                             input int ta, input int tb, input int tc);
        for (int e = first; e <= last; e++) begin
            @(posedge clk);
            #1;
            check_all(tag, e, ta, tb, tc);
        end
    endtask

    // Outputs must be in full reset with no clock edge involved.
    task automatic check_reset_now(input string tag);
        check({tag, " a.dom"},  32'(dom_a),  32'h0000_000F);
        check({tag, " a.done"}, 32'(done_a), 32'd0);
        check({tag, " a.busy"}, 32'(busy_a), 32'd0);
        check({tag, " b.dom"},  32'(dom_b),  32'd1);
        check({tag, " c.dom"},  32'(dom_c),  32'h0000_00FF);
        check({tag, " c.done"}, 32'(done_c), 32'd0);
    endtask

    initial begin
        async_rst  = 1'b0;
        sw_rst_req = 1'b0;
        #1;
        async_rst  = 1'b1;
        #1;
        check_reset_now("por_imm");
        repeat (10) @(posedge clk);
        @(negedge clk);
        check_reset_now("por_hold");

        // Power-up release: T0 = edge 3 (a, c), edge 2 (b).
        async_rst = 1'b0;
        run_edges("pwrup", 1, 70, 3, 2, 3);

        // Software request in ST_RUN, sampled at relative edge 1.
        @(negedge clk);
        sw_rst_req = 1'b1;
        @(posedge clk);
        #1;
        check_all("sw_run", 1, 1, 1, 1);
        @(negedge clk);
        sw_rst_req = 1'b0;
        run_edges("sw_run", 2, 62, 1, 1, 1);

        // Async assert mid-release, checked before any further edge.
        @(negedge clk);
        async_rst = 1'b1;
        @(negedge clk);
        async_rst = 1'b0;
        run_edges("mid", 1, 30, 3, 2, 3);
        check("mid pre a.dom", 32'(dom_a), 32'h0000_000C);
        async_rst = 1'b1;
        #1;
        check_reset_now("mid_imm");
        repeat (2) @(negedge clk);
        async_rst = 1'b0;
        run_edges("mid_rerun", 1, 70, 3, 2, 3);

        // Requests in ST_SYNC are ignored; requests held in ST_HOLD restart the hold.
        @(negedge clk);
        async_rst = 1'b1;
        @(negedge clk);
        async_rst  = 1'b0;
        sw_rst_req = 1'b1;
        run_edges("sw_sync", 1, 2, 3, 2, 3);
        @(negedge clk);
        sw_rst_req = 1'b0;
        run_edges("sw_sync", 3, 4, 3, 2, 3);
        @(negedge clk);
        sw_rst_req = 1'b1;
        for (int e = 5; e <= 9; e++) begin
            @(posedge clk);
            #1;
            check_all("sw_hold", e, e, e, e);
        end
        @(negedge clk);
        sw_rst_req = 1'b0;
        run_edges("sw_hold", 10, 80, 9, 9, 9);

        // Sub-cycle async glitch in ST_RUN: full reset, release still takes SYNC_STAGES edges.
        @(negedge clk);
        async_rst = 1'b1;
        #2;
        async_rst = 1'b0;
        #1;
        check_reset_now("glitch_imm");
        run_edges("glitch", 1, 70, 3, 2, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
